multiword_add_sequencer: RTL and testbench

- Multi-cycle wide adder: adds two `CHUNK_W*N_CHUNKS`-bit operands using one `CHUNK_W`-bit carry-chain stage, processing one chunk per clock, LSB chunk first.
- Carry is registered between chunks.
- Sits between a requester and consumer with valid/ready handshakes on both sides.
- Trades latency for area where a full-width ripple chain would be too slow or too large.

---
 rtl/multiword_add_sequencer.sv | 135 +++++++++++++
 tb/tb_multiword_add_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Chunk-serial wide adder: one CHUNK_W carry stage, LSB chunk first; `MWADD_SUB_EN adds i_sub (A - B).
// Latency: N_CHUNKS cycles from accept to o_valid; one more cycle in DONE when i_ready is high.
// Backpressure: o_ready only in IDLE; i_ready low holds DONE with o_result stable.
module multiword_add_sequencer #(
    parameter int CHUNK_W  = 16,
    parameter int N_CHUNKS = 4,
    localparam int OP_W    = CHUNK_W * N_CHUNKS
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [OP_W-1:0] i_add1,
    input  logic [OP_W-1:0] i_add2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [OP_W:0]   o_result,
    output logic            o_busy
`ifdef MWADD_SUB_EN
    ,
    input  logic            i_sub
`endif
);

    localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OP_W:0]     result_q;

    logic              sub_in;
    logic              last_chunk;
    int unsigned       base;
    logic [OP_W-1:0]   a_shift;
    logic [OP_W-1:0]   b_shift;
    logic [CHUNK_W:0]  chunk_sum;

`ifdef MWADD_SUB_EN
    assign sub_in = i_sub;
`else
    assign sub_in = 1'b0;
`endif

    assign last_chunk = (idx_q == LAST_IDX);

    // Single carry-chain stage shared by every chunk.
    always_comb begin
        base      = 32'(idx_q) * CHUNK_W;
        a_shift   = a_q >> base;
        b_shift   = b_q >> base;
        chunk_sum = {1'b0, a_shift[CHUNK_W-1:0]}
                  + {1'b0, b_shift[CHUNK_W-1:0]}
                  + {{CHUNK_W{1'b0}}, carry_q};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid)    state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (i_ready)    state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        unique case (state_q)
            IDLE:    o_ready = 1'b1;
            RUN:     o_busy  = 1'b1;
            DONE: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
            end
            default: o_ready = 1'b0;
        endcase
    end

    // Subtraction stores ~B and seeds the carry with 1 (two's complement).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_q     <= i_add1;
                        b_q     <= sub_in ? ~i_add2 : i_add2;
                        carry_q <= sub_in;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    result_q[base +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
                    carry_q                   <= chunk_sum[CHUNK_W];
                    if (last_chunk) begin
                        result_q[OP_W] <= chunk_sum[CHUNK_W];
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer: scoreboard queue of expected sums, immediate-assert checks.
module tb_multiword_add_sequencer;

    localparam int CHUNK_W  = 16;
    localparam int N_CHUNKS = 4;
    localparam int OP_W     = CHUNK_W * N_CHUNKS;

    logic            i_clk   = 1'b0;
    logic            i_rst   = 1'b1;
    logic            i_valid = 1'b0;
    logic            i_ready = 1'b1;
    logic [OP_W-1:0] i_add1  = '0;
    logic [OP_W-1:0] i_add2  = '0;
    logic            o_ready;
    logic            o_valid;
    logic            o_busy;
    logic [OP_W:0]   o_result;
`ifdef MWADD_SUB_EN
    logic            i_sub   = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [OP_W:0] exp_q[$];

    multiword_add_sequencer #(
        .CHUNK_W (CHUNK_W),
        .N_CHUNKS(N_CHUNKS)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_add1  (i_add1),
        .i_add2  (i_add2),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_result(o_result),
        .o_busy  (o_busy)
`ifdef MWADD_SUB_EN
        ,
        .i_sub   (i_sub)
`endif
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [OP_W:0] obs, input logic [OP_W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for o_ready, accepts on the next edge, pushes the expected result.
    task automatic issue(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                         input logic sub, output int acc_cyc);
        int n = 0;
        i_valid = 1'b1;
        i_add1  = a;
        i_add2  = b;
`ifdef MWADD_SUB_EN
        i_sub   = sub;
`endif
        while (o_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("issue_wait", 65'(n < 50), 65'd1);
        step();
        acc_cyc = cyc;
        i_valid = 1'b0;
        // Scramble operands after accept: the op in flight must not see them.
        i_add1  = ~a;
        i_add2  = ~b;
        if (sub)
            exp_q.push_back({1'b0, a} + {1'b0, ~b} + 65'd1);
        else
            exp_q.push_back({1'b0, a} + {1'b0, b});
    endtask

    task automatic wait_result(input string tag, input int exp_lat, input bit poke);
        int n = 0;
        logic [OP_W:0] e;
        while (o_valid !== 1'b1 && n < 50) begin
            chk({tag, "_rdy_low"}, 65'(o_ready), 65'd0);
            if (poke) begin
                i_valid = n[0];
                i_add1  = {$urandom, $urandom};
                i_add2  = {$urandom, $urandom};
            end
            step();
            n++;
        end
        i_valid = 1'b0;
        chk({tag, "_wait"}, 65'(n < 50), 65'd1);
        chk({tag, "_lat"}, 65'(n), 65'(exp_lat));
        chk({tag, "_rdy_vs_vld"}, 65'(o_ready), 65'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, o_result, e);
        end else begin
            chk({tag, "_sb"}, 65'(exp_q.size()), 65'd1);
        end
    endtask

    initial begin
        int t1;
        int t2;
        logic [OP_W:0] held;

        #12;
        chk("rst_ready", 65'(o_ready), 65'd1);
        chk("rst_valid", 65'(o_valid), 65'd0);
        chk("rst_busy", 65'(o_busy), 65'd0);
        chk("rst_result", o_result, 65'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step();

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, t1);
        chk("ripple_busy", 65'(o_busy), 65'd1);
        wait_result("ripple", N_CHUNKS, 1'b0);
        chk("ripple_exact", o_result, 65'h1_0000_0000_0000_0000);
        step();
        chk("ripple_idle_ready", 65'(o_ready), 65'd1);
        chk("ripple_idle_busy", 65'(o_busy), 65'd0);

        issue(64'h0001_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, t1);
        wait_result("partial", N_CHUNKS, 1'b0);
        chk("partial_exact", o_result, 65'h0_0001_0000_0001_0000);
        step();

        i_ready = 1'b0;
        issue(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, t1);
        wait_result("bp", N_CHUNKS, 1'b1);
        held = o_result;
        for (int i = 0; i < 5; i++) begin
            i_valid = ~i_valid;
            i_add1  = {$urandom, $urandom};
            i_add2  = {$urandom, $urandom};
            step();
            chk("bp_hold_valid", 65'(o_valid), 65'd1);
            chk("bp_hold_ready", 65'(o_ready), 65'd0);
            chk("bp_hold_result", o_result, held);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        chk("bp_release_ready", 65'(o_ready), 65'd1);
        chk("bp_release_valid", 65'(o_valid), 65'd0);
        chk("bp_release_busy", 65'(o_busy), 65'd0);
        chk("bp_persist_result", o_result, held);

        issue(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, t1);
        step();
        step();
        #2;
        i_rst = 1'b1;
        #1;
        chk("midrst_ready", 65'(o_ready), 65'd1);
        chk("midrst_valid", 65'(o_valid), 65'd0);
        chk("midrst_busy", 65'(o_busy), 65'd0);
        chk("midrst_result", o_result, 65'd0);
        exp_q.delete();
        #3;
        i_rst = 1'b0;
        step();
        issue(64'd5, 64'd7, 1'b0, t1);
        wait_result("post_rst", N_CHUNKS, 1'b0);
        chk("post_rst_exact", o_result, 65'h0_0000_0000_0000_000C);
        step();

        issue(64'd1, 64'd2, 1'b0, t1);
        wait_result("b2b1", N_CHUNKS, 1'b0);
        chk("b2b1_exact", o_result, 65'h3);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, t2);
        chk("b2b_gap", 65'(t2 - t1), 65'(N_CHUNKS + 2));
        wait_result("b2b2", N_CHUNKS, 1'b0);
        chk("b2b2_exact", o_result, 65'h1_0000_0000_0000_0000);
        step();

`ifdef MWADD_SUB_EN
        issue(64'd5, 64'd3, 1'b1, t1);
        wait_result("sub_pos", N_CHUNKS, 1'b0);
        chk("sub_pos_exact", o_result, 65'h1_0000_0000_0000_0002);
        step();
        issue(64'd3, 64'd5, 1'b1, t1);
        wait_result("sub_neg", N_CHUNKS, 1'b0);
        chk("sub_neg_exact", o_result, 65'h0_FFFF_FFFF_FFFF_FFFE);
        step();
        issue(64'd9, 64'd4, 1'b0, t1);
        wait_result("sub_off_add", N_CHUNKS, 1'b0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
